commu_frame_tx: RTL and testbench

//  Parametrised successor of the per-slot TX datapath: one block builds a complete frame and serialises it.

---
 rtl/commu_frame_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_commu_frame_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commu_frame_tx.sv
// Frame builder and serialiser: sync, id, payload and tail words sent on NCH redundant RS-485 channels.
// Optional macro COMMU_CRC_EN selects a CRC-16-CCITT tail instead of the additive checksum.
module commu_frame_tx #(
    parameter int          DW    = 16,
    parameter int          NCH   = 2,
    parameter int          GUARD = 2,
    parameter logic [15:0] SYNC  = 16'hEB90
) (
    input  logic           i_clk_sys,
    input  logic           i_rst,
    input  logic           i_fire,
    output logic           o_done,
    output logic           o_busy,
    input  logic [15:0]    i_len_pkg,
    input  logic [19:0]    i_tbit_period,
    input  logic [7:0]     i_dev_id,
    input  logic [NCH-1:0] i_ch_en,
    output logic           o_buf_rd,
    input  logic [DW-1:0]  i_buf_q,
    output logic [NCH-1:0] o_tx,
    output logic [NCH-1:0] o_de
);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SYNC, S_ID, S_PAY, S_TAIL, S_TRAIL} state_t;

    localparam int            BW          = $clog2(DW + GUARD + 2) + 1;
    localparam logic [BW-1:0] B_STOP      = BW'(DW + 1);
    localparam logic [BW-1:0] B_DATA_LAST = BW'(DW);
    localparam logic [BW-1:0] B_GLAST     = BW'(GUARD - 1);

`ifdef COMMU_CRC_EN
    localparam logic [DW-1:0] TAIL_INIT = DW'(16'hFFFF);

    function automatic logic [DW-1:0] f_tail_next(input logic [DW-1:0] acc, input logic [DW-1:0] word);
        logic [15:0] c;
        logic        fb;
        c = acc[15:0];
        for (int i = 0; i < DW; i++) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return DW'(c);
    endfunction
`else
    localparam logic [DW-1:0] TAIL_INIT = '0;

    function automatic logic [DW-1:0] f_tail_next(input logic [DW-1:0] acc, input logic [DW-1:0] word);
        return acc + word;
    endfunction
`endif

    state_t         r_state, w_state;
    logic [19:0]    r_pcnt, w_pcnt, r_period, w_period;
    logic [BW-1:0]  r_bcnt, w_bcnt;
    logic [15:0]    r_wcnt, w_wcnt, r_rdcnt, w_rdcnt, r_len, w_len;
    logic [DW-1:0]  r_shift, w_shift, r_sum, w_sum, r_idword, w_idword, r_bufq, w_word;
    logic [NCH-1:0] r_chen, w_chen, r_tx, w_tx, r_de, w_de;
    logic [7:0]     r_seq, w_seq;
    logic           r_busy, w_busy, r_done, w_done, r_rd, w_rd, r_rd_d, w_finish;
    logic           w_bit_end;

    assign w_bit_end = (r_pcnt == r_period - 20'd1);

    // Next-state and datapath: bit timing, word sequencing, buffer strobes and tail accumulation.
    always_comb begin
        w_state  = r_state;
        w_pcnt   = r_pcnt;
        w_bcnt   = r_bcnt;
        w_wcnt   = r_wcnt;
        w_rdcnt  = r_rdcnt;
        w_shift  = r_shift;
        w_sum    = r_sum;
        w_len    = r_len;
        w_period = r_period;
        w_idword = r_idword;
        w_chen   = r_chen;
        w_seq    = r_seq;
        w_tx     = r_tx;
        w_de     = r_de;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_rd     = 1'b0;
        w_word   = '0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A fire coinciding with the done pulse still belongs to the finished frame.
                if (i_fire && !r_done) begin
                    w_busy   = 1'b1;
                    w_de     = i_ch_en;
                    w_chen   = i_ch_en;
                    w_period = (i_tbit_period == 20'd0) ? 20'd1 : i_tbit_period;
                    w_len    = i_len_pkg;
                    w_idword = DW'({i_dev_id, r_seq});
                    w_sum    = TAIL_INIT;
                    w_rdcnt  = 16'd0;
                    w_wcnt   = 16'd0;
                    w_pcnt   = 20'd0;
                    w_bcnt   = '0;
                    w_state  = (GUARD == 0) ? S_SYNC : S_LEAD;
                    w_tx     = (GUARD == 0) ? ~i_ch_en : '1;
                end else begin
                    w_tx = '1;
                    w_de = '0;
                end
            end
            S_LEAD, S_TRAIL: begin
                if (w_bit_end) begin
                    w_pcnt = 20'd0;
                    if (r_bcnt == B_GLAST) begin
                        if (r_state == S_LEAD) begin
                            w_state = S_SYNC;
                            w_bcnt  = '0;
                            w_tx    = ~r_chen;
                        end else begin
                            w_finish = 1'b1;
                        end
                    end else begin
                        w_bcnt = r_bcnt + BW'(1);
                    end
                end else begin
                    w_pcnt = r_pcnt + 20'd1;
                end
            end
            S_SYNC, S_ID, S_PAY, S_TAIL: begin
                if (w_bit_end) begin
                    w_pcnt = 20'd0;
                    if (r_bcnt == B_STOP) begin
                        w_bcnt = '0;
                        w_tx   = ~r_chen;
                        case (r_state)
                            S_SYNC:  w_state = S_ID;
                            S_ID:    w_state = (r_len == 16'd0) ? S_TAIL : S_PAY;
                            S_PAY: begin
                                if (r_wcnt == r_len - 16'd1) begin
                                    w_state = S_TAIL;
                                end else begin
                                    w_wcnt = r_wcnt + 16'd1;
                                end
                            end
                            default: begin
                                w_tx = '1;
                                if (GUARD == 0) begin
                                    w_finish = 1'b1;
                                end else begin
                                    w_state = S_TRAIL;
                                end
                            end
                        endcase
                    end else if (r_bcnt == '0) begin
                        w_bcnt = r_bcnt + BW'(1);
                        case (r_state)
                            S_SYNC:  w_word = DW'(SYNC);
                            S_ID:    w_word = r_idword;
                            S_PAY:   w_word = r_rd_d ? i_buf_q : r_bufq;
                            default: w_word = r_sum;
                        endcase
                        w_tx    = {NCH{w_word[0]}} | ~r_chen;
                        w_shift = w_word >> 1;
                        if (r_state == S_ID || r_state == S_PAY) begin
                            w_sum = f_tail_next(r_sum, w_word);
                        end else begin
                            w_sum = r_sum;
                        end
                    end else if (r_bcnt == B_DATA_LAST) begin
                        w_bcnt = B_STOP;
                        w_tx   = '1;
                        // Prefetch the next payload word during this stop bit.
                        if ((r_state == S_ID || r_state == S_PAY) && (r_rdcnt < r_len)) begin
                            w_rd    = 1'b1;
                            w_rdcnt = r_rdcnt + 16'd1;
                        end else begin
                            w_rd = 1'b0;
                        end
                    end else begin
                        w_bcnt  = r_bcnt + BW'(1);
                        w_tx    = {NCH{r_shift[0]}} | ~r_chen;
                        w_shift = r_shift >> 1;
                    end
                end else begin
                    w_pcnt = r_pcnt + 20'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
        if (w_finish) begin
            w_state = S_IDLE;
            w_tx    = '1;
            w_de    = '0;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_seq   = r_seq + 8'd1;
        end else begin
            w_done = 1'b0;
        end
    end

    // State and datapath registers; buffer data is captured the cycle after the read strobe.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_pcnt   <= 20'd0;
            r_period <= 20'd1;
            r_bcnt   <= '0;
            r_wcnt   <= 16'd0;
            r_rdcnt  <= 16'd0;
            r_len    <= 16'd0;
            r_shift  <= '0;
            r_sum    <= '0;
            r_idword <= '0;
            r_bufq   <= '0;
            r_chen   <= '0;
            r_tx     <= '1;
            r_de     <= '0;
            r_seq    <= 8'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd     <= 1'b0;
            r_rd_d   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pcnt   <= w_pcnt;
            r_period <= w_period;
            r_bcnt   <= w_bcnt;
            r_wcnt   <= w_wcnt;
            r_rdcnt  <= w_rdcnt;
            r_len    <= w_len;
            r_shift  <= w_shift;
            r_sum    <= w_sum;
            r_idword <= w_idword;
            r_chen   <= w_chen;
            r_tx     <= w_tx;
            r_de     <= w_de;
            r_seq    <= w_seq;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_rd     <= w_rd;
            r_rd_d   <= r_rd;
            if (r_rd_d) begin
                r_bufq <= i_buf_q;
            end else begin
                r_bufq <= r_bufq;
            end
        end
    end

    assign o_tx     = r_tx;
    assign o_de     = r_de;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_buf_rd = r_rd;

endmodule

// File: tb/tb_commu_frame_tx.sv
// Self-checking bench for commu_frame_tx: randomized frames compared cycle by cycle
// against a waveform reference built from the frame-format rules.
module tb_commu_frame_tx;

    localparam int DW    = 16;
    localparam int NCH   = 2;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fire;
    logic        done, busy, buf_rd;
    logic [15:0] len_pkg;
    logic [19:0] tbit;
    logic [7:0]  dev_id;
    logic [1:0]  ch_en;
    logic [15:0] buf_q;
    logic [1:0]  tx, de;

    always #5 clk = ~clk;

    commu_frame_tx #(.DW(DW), .NCH(NCH), .GUARD(GUARD), .SYNC(16'hEB90)) dut (
        .i_clk_sys(clk), .i_rst(rst), .i_fire(fire), .o_done(done), .o_busy(busy),
        .i_len_pkg(len_pkg), .i_tbit_period(tbit), .i_dev_id(dev_id), .i_ch_en(ch_en),
        .o_buf_rd(buf_rd), .i_buf_q(buf_q), .o_tx(tx), .o_de(de)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Packet buffer model: data appears the cycle after each read strobe.
    logic [15:0] pay [0:15];
    int          rd_idx;
    always @(posedge clk) begin
        if (rst) begin
            rd_idx <= 0;
        end else if (buf_rd) begin
            buf_q  <= pay[rd_idx % 16];
            rd_idx <= rd_idx + 1;
        end else if (!busy) begin
            rd_idx <= 0;
        end
    end

    // Reference model state
    int          m_seq;
    logic [15:0] exp_words[$];
    logic        exp_bits[$];
    logic        exp_rdq[$];

    // Observations from the last frame
    int          obs_mism, obs_first, obs_done_cyc, obs_rdcnt;
    logic [1:0]  obs_rst_tx, obs_rst_de;
    logic        obs_rst_busy;

    task automatic build_model(input int len, input int p, input logic [7:0] id, input logic [7:0] seq);
        int          sum;
        logic [15:0] crc, w, tail;
        logic        fb, bv;
        exp_words.delete();
        exp_bits.delete();
        exp_rdq.delete();
        exp_words.push_back(16'hEB90);
        exp_words.push_back({id, seq});
        for (int k = 0; k < len; k++) exp_words.push_back(pay[k]);
        sum = 0;
        crc = 16'hFFFF;
        for (int i = 1; i < exp_words.size(); i++) begin
            w   = exp_words[i];
            sum = sum + int'(w);
            for (int b = 0; b < 16; b++) begin
                fb  = crc[15] ^ w[b];
                crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
`ifdef COMMU_CRC_EN
        tail = crc;
`else
        tail = 16'(sum % 65536);
`endif
        exp_words.push_back(tail);
        for (int i = 0; i < GUARD * p; i++) begin
            exp_bits.push_back(1'b1);
            exp_rdq.push_back(1'b0);
        end
        for (int wi = 0; wi < exp_words.size(); wi++) begin
            w = exp_words[wi];
            for (int b = 0; b < 18; b++) begin
                bv = (b == 0) ? 1'b0 : (b == 17) ? 1'b1 : w[b-1];
                for (int c = 0; c < p; c++) begin
                    exp_bits.push_back(bv);
                    exp_rdq.push_back((b == 17) && (c == 0) && (wi >= 1) && (wi <= len));
                end
            end
        end
        for (int i = 0; i < GUARD * p; i++) begin
            exp_bits.push_back(1'b1);
            exp_rdq.push_back(1'b0);
        end
    endtask

    // Fires one frame and compares every cycle against the reference; optional extra fires and reset.
    task automatic do_frame(input int len, input int tbp, input logic [7:0] id, input logic [1:0] chen,
                            input int fire_mid, input bit fire_done, input int rst_at);
        int         p, total;
        logic [1:0] e_tx, e_de;
        logic       e_busy, e_done, e_rd, line;
        bit         aborted;
        p = (tbp == 0) ? 1 : tbp;
        build_model(len, p, id, 8'(m_seq));
        total = p * (2 * GUARD + (3 + len) * 18);
        @(negedge clk);
        len_pkg = 16'(len);
        tbit    = 20'(tbp);
        dev_id  = id;
        ch_en   = chen;
        fire    = 1'b1;
        @(negedge clk);
        fire    = 1'b0;
        // Sampled-at-fire inputs are scrambled to show they are not reused.
        len_pkg = 16'($urandom_range(0, 9));
        tbit    = 20'($urandom_range(0, 7));
        dev_id  = 8'($urandom);
        ch_en   = 2'($urandom);
        obs_mism = 0; obs_first = -1; obs_done_cyc = -1; obs_rdcnt = 0;
        aborted  = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            if (c <= total) begin
                line   = exp_bits[c-1];
                e_tx   = {line, line} | ~chen;
                e_de   = chen;
                e_busy = 1'b1;
                e_done = 1'b0;
                e_rd   = exp_rdq[c-1];
            end else begin
                e_tx = 2'b11; e_de = 2'b00; e_busy = 1'b0; e_done = 1'b1; e_rd = 1'b0;
            end
            if (tx !== e_tx || de !== e_de || busy !== e_busy || done !== e_done || buf_rd !== e_rd) begin
                obs_mism++;
                if (obs_first < 0) obs_first = c;
            end
            if (buf_rd === 1'b1) obs_rdcnt++;
            if (done === 1'b1 && obs_done_cyc < 0) obs_done_cyc = c;
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                obs_rst_tx   = tx;
                obs_rst_de   = de;
                obs_rst_busy = busy;
                aborted      = 1'b1;
                break;
            end
            fire = (c == fire_mid) || (c == total + 1 && fire_done);
            @(negedge clk);
            fire = 1'b0;
        end
        if (!aborted) m_seq = (m_seq + 1) % 256;
    endtask

    task automatic test_reset;
        rst = 1'b1; fire = 1'b0; len_pkg = 16'd0; tbit = 20'd1; dev_id = 8'd0; ch_en = 2'b00;
        m_seq = 0;
        repeat (3) @(negedge clk);
        n_total++; if (tx !== 2'b11) $display("FAIL reset_tx: got %b expected 11", tx); else n_pass++;
        n_total++; if (de !== 2'b00) $display("FAIL reset_de: got %b expected 00", de); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++; if (buf_rd !== 1'b0) $display("FAIL reset_buf_rd: got %b expected 0", buf_rd); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame;
        pay[0] = 16'h1234; pay[1] = 16'h0001;
        do_frame(2, 4, 8'h05, 2'b11, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t1_wave: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
        n_total++; if (obs_done_cyc !== 377) $display("FAIL t1_done_cycle: got %0d expected 377", obs_done_cyc); else n_pass++;
        n_total++; if (obs_rdcnt !== 2) $display("FAIL t1_buf_rd_count: got %0d expected 2", obs_rdcnt); else n_pass++;
    endtask

    task automatic test_channel_mask;
        pay[0] = 16'h1234; pay[1] = 16'h0001;
        do_frame(2, 4, 8'h05, 2'b10, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t2_wave: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
        n_total++; if (obs_done_cyc !== 377) $display("FAIL t2_done_cycle: got %0d expected 377", obs_done_cyc); else n_pass++;
        do_frame(1, 2, 8'h33, 2'b00, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t2_no_channels: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
    endtask

    task automatic test_empty_fast;
        do_frame(0, 0, 8'h05, 2'b11, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t3_wave: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
        n_total++; if (obs_done_cyc !== 59) $display("FAIL t3_done_cycle: got %0d expected 59", obs_done_cyc); else n_pass++;
        n_total++; if (obs_rdcnt !== 0) $display("FAIL t3_buf_rd_count: got %0d expected 0", obs_rdcnt); else n_pass++;
    endtask

    task automatic test_fire_ignored;
        int busy_hits;
        pay[0] = 16'hA5A5;
        do_frame(1, 1, 8'h05, 2'b11, 30, 1'b1, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t4_wave: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
        busy_hits = 0;
        repeat (4) begin
            if (busy !== 1'b0) busy_hits++;
            @(negedge clk);
        end
        n_total++; if (busy_hits !== 0) $display("FAIL t4_done_fire_ignored: busy seen %0d cycles expected 0", busy_hits); else n_pass++;
        do_frame(1, 1, 8'h05, 2'b11, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t4_next_frame: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
    endtask

    task automatic test_async_reset;
        int done_hits;
        pay[0] = 16'h1234; pay[1] = 16'h0001;
        do_frame(2, 4, 8'h05, 2'b11, 0, 1'b0, 170);
        n_total++; if (obs_rst_tx !== 2'b11) $display("FAIL t5_rst_tx: got %b expected 11", obs_rst_tx); else n_pass++;
        n_total++; if (obs_rst_de !== 2'b00) $display("FAIL t5_rst_de: got %b expected 00", obs_rst_de); else n_pass++;
        n_total++; if (obs_rst_busy !== 1'b0) $display("FAIL t5_rst_busy: got %b expected 0", obs_rst_busy); else n_pass++;
        m_seq = 0;
        @(negedge clk);
        rst = 1'b0;
        done_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0) done_hits++;
        end
        n_total++; if (done_hits !== 0) $display("FAIL t5_no_done: got %0d pulses expected 0", done_hits); else n_pass++;
        do_frame(2, 4, 8'h05, 2'b11, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t5_after_reset: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
    endtask

    task automatic test_random;
        int len, tbp;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(0, 5);
            tbp = $urandom_range(0, 3);
            for (int k = 0; k < 16; k++) pay[k] = 16'($urandom);
            do_frame(len, tbp, 8'($urandom), 2'($urandom_range(0, 3)), 0, 1'b0, 0);
            n_total++;
            if (obs_mism !== 0) $display("FAIL rand_frame_%0d: %0d bad cycles (first %0d) expected 0", f, obs_mism, obs_first);
            else n_pass++;
        end
    endtask

    task automatic test_crc_and_wrap;
        int bad_frames;
        pay[0] = 16'h0000;
        do_frame(1, 1, 8'h00, 2'b11, 0, 1'b0, 0);
        n_total++; if (obs_mism !== 0) $display("FAIL t6_tail: %0d bad cycles (first %0d) expected 0", obs_mism, obs_first); else n_pass++;
        bad_frames = 0;
        for (int f = 0; f < 256; f++) begin
            do_frame(0, 1, 8'h00, 2'b01, 0, 1'b0, 0);
            if (obs_mism != 0) bad_frames++;
        end
        n_total++; if (bad_frames !== 0) $display("FAIL t6_seq_wrap: got %0d bad frames expected 0", bad_frames); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_channel_mask();
        test_empty_fast();
        test_fire_ignored();
        test_async_reset();
        test_random();
        test_crc_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
